// File: rtl/modulus_iter_hs.sv
// Iterative unsigned modulus with valid/ready handshakes, one quotient bit per cycle.
// Optional quotient output is enabled by defining MODULUS_QUOTIENT_OUT_EN.
module modulus_iter_hs #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef MODULUS_QUOTIENT_OUT_EN
    output logic [WIDTH-1:0] quotient,
`endif
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
`ifdef MODULUS_QUOTIENT_OUT_EN
    logic [WIDTH-1:0] quo_q, quo_d;
`endif

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_nx;
    logic             ge;
    logic             sh_in;

    // One restoring-division step; a set top bit means the remainder
    // already exceeds any divisor, so it forces a subtract.
    always_comb begin
        rem_sh = {rem_q[WIDTH-1:0], a_sh_q[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, div_q}) || rem_q[WIDTH];
        rem_nx = ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
`ifdef MODULUS_QUOTIENT_OUT_EN
        sh_in  = ge;
`else
        sh_in  = 1'b0;
`endif
    end

    // Next-state and datapath control for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        div_d   = div_q;
        res_d   = res_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
`ifdef MODULUS_QUOTIENT_OUT_EN
        quo_d   = quo_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    div_d   = b;
                    dbz_d   = (b == '0);
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                a_sh_d = {a_sh_q[WIDTH-2:0], sh_in};
                rem_d  = rem_nx;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = rem_nx[WIDTH-1:0];
`ifdef MODULUS_QUOTIENT_OUT_EN
                    quo_d   = {a_sh_q[WIDTH-2:0], ge};
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            div_q   <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef MODULUS_QUOTIENT_OUT_EN
            quo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            div_q   <= div_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
`ifdef MODULUS_QUOTIENT_OUT_EN
            quo_q   <= quo_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign result      = res_q;
    assign div_by_zero = dbz_q;
`ifdef MODULUS_QUOTIENT_OUT_EN
    assign quotient    = quo_q;
`endif

endmodule

// File: doc/modulus_iter_hs.md
Name: modulus_iter_hs

Overview:
- Parametrised successor to the fixed 16-bit flopped modulus unit.
- Computes result = a mod b (unsigned) for a configurable WIDTH using an iterative restoring-division datapath, one quotient bit per cycle.
- Uses a valid/ready handshake on input and output.
- Sits between operand-producing logic and result consumers that can tolerate multi-cycle latency in exchange for small area.

Parameters:
- WIDTH, 16: operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH)+1: width of the internal iteration counter; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is immediate, deassertion is synchronised externally.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  dividend, unsigned.
- b  input  WIDTH  divisor, unsigned.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  a mod b; equals a when b==0.
- div_by_zero  output  1  captured b was 0; qualified by out_valid.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; result=0; div_by_zero=0.
  - Operand, remainder and counter registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid&in_ready: capture a into the shift register, b into the divisor register, and div_by_zero=(b==0).
  - Clear the remainder register (WIDTH+1 bits), set counter=WIDTH, then go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: r' = {r[WIDTH-1:0], a_sh[MSB]}; shift a_sh left by 1.
  - If r' >= {1'b0,b}, then r = r' - b; else r = r'. Decrement counter.
  - On the edge where the counter goes 1->0: load result=r[WIDTH-1:0] and go to DONE.
- DONE:
  - out_valid=1; result and div_by_zero held stable until the handshake.
  - On an edge with out_valid&out_ready, go to IDLE.
  - in_ready is not asserted in DONE; it is first high the cycle after the handshake.
- Latency:
  - out_valid first high exactly WIDTH rising edges after the accepting edge, independent of operand values, b==0 included.
  - Maximum throughput: one operation per WIDTH+2 cycles when out_ready is tied high.
- Divide by zero:
  - With b=0 the natural algorithm yields r=a. result=a and div_by_zero=1; no special-case path.
- Boundaries:
  - a<b gives result=a. a==b gives 0. b==1 gives 0.
  - a=all-ones with b=all-ones gives 0.
  - The WIDTH+1-bit remainder register prevents overflow when r' exceeds 2^WIDTH-1.
- Protocol rules:
  - in_valid while in_ready=0 is ignored; no queuing.
  - a/b changes during CALC/DONE have no effect.
  - out_ready while out_valid=0 has no effect.
  - Once out_valid rises, the result is never dropped or altered until accepted.
- Reset mid-operation (CALC or DONE): the operation is aborted, all outputs take reset values immediately, and no result is produced for the aborted operands.

Optional Feature:
- Macro MODULUS_QUOTIENT_OUT_EN.
- Defined:
  - Adds output port quotient [WIDTH-1:0].
  - Each CALC edge shifts in 1 if r' >= b, else 0. Loaded alongside result at the CALC->DONE edge and held under the same rules.
  - Reset value 0. With b=0, quotient = all-ones.
- Undefined: no quotient port or register; behaviour otherwise identical.

Test Plan:
- WIDTH=16, reset then a=1000, b=7, out_ready=1:
  - Accept on edge N; out_valid high after edge N+16; result=6, div_by_zero=0.
  - With the macro: quotient=142.
- a=0xFFFF, b=0xFFFF -> result=0. a=5, b=9 -> result=5. a=0x8000, b=1 -> result=0.
- a=0x1234, b=0 -> result=0x1234, div_by_zero=1, same 16-cycle latency; with the macro, quotient=0xFFFF.
- out_ready low for 10 cycles after out_valid rises:
  - result stays stable and in_ready stays 0.
  - in_valid pulses with new operands are ignored.
  - After the out_ready handshake, in_ready=1 on the next cycle.
- rst_n pulsed low for one cycle at CALC cycle 8:
  - Outputs return to reset values immediately.
  - No out_valid for the aborted operation.
  - The next op a=100, b=30 completes with result=10.
- Back-to-back ops with out_ready tied high and in_valid tied high:
  - Accept edges spaced exactly 18 cycles apart.
  - Random 1000-op sweep with WIDTH=8 and WIDTH=32 checked against a reference mod; b=0 yields a.
